// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle ARM-subset control unit.
// Latency: n/a (types, constants and one pure decode function).
// Backpressure: n/a.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
  } state_t;

  // ALUControl codes; EOR and MOV only exist in the 3-bit build
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;
  localparam logic [2:0] ALU_MOV = 3'd5;

  // Funct[4:1] command encodings
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Condition field encodings
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  // Datapath mux selects
  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;
  localparam logic       SRCA_RN    = 1'b0;
  localparam logic       SRCA_PC    = 1'b1;
  localparam logic [1:0] SRCB_RM    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // Moore outputs of one state, before condition/handshake gating
  typedef struct packed {
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       fetch;
    logic       exec;
    logic       aluwb;
  } ctl_t;

  function automatic ctl_t state_ctl(state_t s);
    ctl_t c;
    c = '0;
    c.adrsrc    = ADR_PC;
    c.alusrca   = SRCA_RN;
    c.alusrcb   = SRCB_RM;
    c.resultsrc = RES_ALUOUT;
    case (s)
      S_FETCH:    begin c.alusrca = SRCA_PC; c.alusrcb = SRCB_FOUR; c.resultsrc = RES_ALURES; c.fetch = 1'b1; end
      S_DECODE:   begin c.alusrca = SRCA_PC; c.alusrcb = SRCB_FOUR; c.resultsrc = RES_ALURES; end
      S_MEMADR:   c.alusrcb = SRCB_IMM;
      S_MEMREAD:  c.adrsrc = ADR_ALUOUT;
      S_MEMWB:    begin c.resultsrc = RES_RDATA; c.regw = 1'b1; end
      S_MEMWRITE: begin c.adrsrc = ADR_ALUOUT; c.memw = 1'b1; end
      S_EXECR:    begin c.alusrcb = SRCB_RM; c.exec = 1'b1; end
      S_EXECI:    begin c.alusrcb = SRCB_IMM; c.exec = 1'b1; end
      S_ALUWB:    begin c.resultsrc = RES_ALUOUT; c.regw = 1'b1; c.aluwb = 1'b1; end
      S_BRANCH:   begin c.alusrcb = SRCB_IMM; c.resultsrc = RES_ALURES; c.branch = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_cond_unit.sv
// NZCV flag register plus condition-pass evaluation against the registered flags.
// Latency: flags load on the clock edge after a write strobe; CondEx is combinational.
// Backpressure: none.
module cond_unit
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic       FlagWriteNZ,
  input  logic       FlagWriteCV,
  output logic [3:0] Flags,
  output logic       CondEx
);

  logic fn, fz, fc, fv;
  assign {fn, fz, fc, fv} = Flags;

  // N/Z and C/V halves load independently so logical ops keep the old carry/overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Flags <= 4'b0000;
    end else begin
      if (FlagWriteNZ) Flags[3:2] <= ALUFlags[3:2];
      if (FlagWriteCV) Flags[1:0] <= ALUFlags[1:0];
    end
  end

  // Condition check; the 1111 encoding never executes
  always_comb begin
    case (Cond)
      COND_EQ: CondEx = fz;
      COND_NE: CondEx = ~fz;
      COND_CS: CondEx = fc;
      COND_CC: CondEx = ~fc;
      COND_MI: CondEx = fn;
      COND_PL: CondEx = ~fn;
      COND_VS: CondEx = fv;
      COND_VC: CondEx = ~fv;
      COND_HI: CondEx = fc & ~fz;
      COND_LS: CondEx = ~fc | fz;
      COND_GE: CondEx = (fn == fv);
      COND_LT: CondEx = (fn != fv);
      COND_GT: CondEx = ~fz & (fn == fv);
      COND_LE: CondEx = fz | (fn != fv);
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control: decodes the instruction fields, sequences FETCH..WB and gates all writes by condition.
// Latency: DP 4, LDR 5, STR 4, B 3, illegal 2 cycles with MemReady high; each MemReady-low memory cycle adds one.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until MemReady; reset drops every write enable immediately.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           Cond,
  input  logic [1:0]           OP,
  input  logic [5:0]           Funct,
  input  logic [3:0]           RD,
  input  logic [3:0]           ALUFlags,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           Flags,
  output logic                 Illegal
);

  state_t     state, state_nxt;
  ctl_t       ctl;
  logic [2:0] alu_dec, alu_sel;
  logic       dp_legal, cmd_cv, is_cmp, illegal_dec;
  logic       condex, regw_eff, flagw_nz, flagw_cv;

  // Data-processing command decode; EOR/MOV are only legal when the ALU has a third select bit
  always_comb begin
    alu_dec  = ALU_ADD;
    dp_legal = 1'b1;
    cmd_cv   = 1'b0;
    is_cmp   = 1'b0;
    case (Funct[4:1])
      CMD_ADD: begin alu_dec = ALU_ADD; cmd_cv = 1'b1; end
      CMD_SUB: begin alu_dec = ALU_SUB; cmd_cv = 1'b1; end
      CMD_AND: alu_dec = ALU_AND;
      CMD_ORR: alu_dec = ALU_ORR;
      CMD_CMP: begin alu_dec = ALU_SUB; cmd_cv = 1'b1; is_cmp = 1'b1; end
      CMD_EOR: begin alu_dec = ALU_EOR; dp_legal = (ALUCTRL_W >= 3); end
      CMD_MOV: begin alu_dec = ALU_MOV; dp_legal = (ALUCTRL_W >= 3); end
      default: dp_legal = 1'b0;
    endcase
  end

  assign illegal_dec = (OP == 2'b11) | ((OP == OP_DP) & ~dp_legal);

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    if (MemReady) state_nxt = S_DECODE;
      S_DECODE: begin
        if (illegal_dec)       state_nxt = S_FETCH;
        else if (OP == OP_MEM) state_nxt = S_MEMADR;
        else if (OP == OP_DP)  state_nxt = Funct[5] ? S_EXECI : S_EXECR;
        else if (OP == OP_BR)  state_nxt = S_BRANCH;
        else                   state_nxt = S_FETCH;
      end
      S_MEMADR:   state_nxt = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (MemReady) state_nxt = S_MEMWB;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: if (MemReady) state_nxt = S_FETCH;
      S_EXECR,
      S_EXECI:    state_nxt = S_ALUWB;
      S_ALUWB,
      S_BRANCH:   state_nxt = S_FETCH;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // State register with the Moore outputs of the next state registered alongside it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      ctl   <= state_ctl(S_FETCH);
    end else begin
      state <= state_nxt;
      ctl   <= state_ctl(state_nxt);
    end
  end

  // Flags only load during EXEC of an S-suffixed instruction that passes its condition
  assign flagw_nz = ctl.exec & Funct[0] & condex;
  assign flagw_cv = flagw_nz & cmd_cv;

  cond_unit u_cond (
    .clk         (clk),
    .reset       (reset),
    .Cond        (Cond),
    .ALUFlags    (ALUFlags),
    .FlagWriteNZ (flagw_nz),
    .FlagWriteCV (flagw_cv),
    .Flags       (Flags),
    .CondEx      (condex)
  );

  // Write enables; reset masks them combinationally so nothing waits for a clock edge
  assign regw_eff = ctl.regw & ~(ctl.aluwb & is_cmp) & condex & ~reset;
  assign RegWrite = regw_eff & (RD != 4'd15);
  assign MemWrite = ctl.memw & condex & ~reset;
  assign IRWrite  = ctl.fetch & MemReady & ~reset;
  assign PCWrite  = IRWrite | (ctl.branch & condex & ~reset) | (regw_eff & (RD == 4'd15));

  // Datapath selects straight from the registered state decode
  assign AdrSrc    = ctl.adrsrc;
  assign ALUSrcA   = ctl.alusrca;
  assign ALUSrcB   = ctl.alusrcb;
  assign ResultSrc = ctl.resultsrc;
  assign ImmSrc    = OP;
  assign RegSrc    = {OP == OP_MEM, OP == OP_BR};

  // ALU runs the decoded command in EXEC/ALUWB and adds everywhere else
  assign alu_sel    = (ctl.exec | ctl.aluwb) ? alu_dec : ALU_ADD;
  assign ALUControl = ALUCTRL_W'(alu_sel);

  assign Illegal = (state == S_DECODE) & illegal_dec;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: table of instructions with per-cycle expected enable masks, plus reset and 3-bit ALU sequences.
// Latency: checks each instruction's cycle count through the IRWrite pattern.
// Backpressure: MemReady stalls applied at chosen cycle indices.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset, MemReady;
  logic [3:0] Cond, RD, ALUFlags;
  logic [1:0] OP;
  logic [5:0] Funct;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, Illegal;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
  logic [3:0] Flags;

  logic       reset3, MemReady3;
  logic [3:0] Cond3, RD3, ALUFlags3;
  logic [1:0] OP3;
  logic [5:0] Funct3;
  logic       PCWrite3, IRWrite3, RegWrite3, MemWrite3, AdrSrc3, ALUSrcA3, Illegal3;
  logic [1:0] ALUSrcB3, ResultSrc3, ImmSrc3, RegSrc3;
  logic [2:0] ALUControl3;
  logic [3:0] Flags3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multicycle_control #(.ALUCTRL_W(2)) u_dut (
    .clk(clk), .reset(reset), .Cond(Cond), .OP(OP), .Funct(Funct), .RD(RD),
    .ALUFlags(ALUFlags), .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl), .Flags(Flags), .Illegal(Illegal)
  );

  multicycle_control #(.ALUCTRL_W(3)) u_dut3 (
    .clk(clk), .reset(reset3), .Cond(Cond3), .OP(OP3), .Funct(Funct3), .RD(RD3),
    .ALUFlags(ALUFlags3), .MemReady(MemReady3), .PCWrite(PCWrite3), .IRWrite(IRWrite3),
    .RegWrite(RegWrite3), .MemWrite(MemWrite3), .AdrSrc(AdrSrc3), .ALUSrcA(ALUSrcA3),
    .ALUSrcB(ALUSrcB3), .ResultSrc(ResultSrc3), .ImmSrc(ImmSrc3), .RegSrc(RegSrc3),
    .ALUControl(ALUControl3), .Flags(Flags3), .Illegal(Illegal3)
  );

  typedef struct {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [3:0]  aflg;
    int          stall_at;
    int          stall_n;
    int          len;
    logic [15:0] irw, pcw, regw, memw, ill;
    logic [3:0]  flags;
    logic [2:0]  alu;
    logic [5:0]  sel;
  } vec_t;

  typedef struct {
    logic [15:0] irw, pcw, regw, memw, ill;
    logic [3:0]  flags;
    logic [2:0]  alu;
    logic [5:0]  sel;
  } obs_t;

  localparam int NV = 18;
  vec_t vecs[NV];
  vec_t exp_q[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One instruction from its FETCH cycle; entered and left at posedge+1
  task automatic run_vec(input int idx, input vec_t v);
    obs_t o;
    vec_t e;
    o.irw = '0; o.pcw = '0; o.regw = '0; o.memw = '0; o.ill = '0;
    o.flags = '0; o.alu = '0; o.sel = '0;
    Cond = v.cond; OP = v.op; Funct = v.funct; RD = v.rd; ALUFlags = v.aflg;
    exp_q.push_back(v);
    for (int c = 0; c < v.len; c++) begin
      MemReady = (c >= v.stall_at && c < v.stall_at + v.stall_n) ? 1'b0 : 1'b1;
      @(negedge clk);
      o.irw[c[3:0]]  = IRWrite;
      o.pcw[c[3:0]]  = PCWrite;
      o.regw[c[3:0]] = RegWrite;
      o.memw[c[3:0]] = MemWrite;
      o.ill[c[3:0]]  = Illegal;
      if (c == v.len - 1) begin
        o.flags = Flags;
        o.alu   = {1'b0, ALUControl};
        o.sel   = {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc};
      end
      @(posedge clk); #1;
    end
    e = exp_q.pop_front();
    chk($sformatf("v%0d_irw", idx),   o.irw,  e.irw);
    chk($sformatf("v%0d_pcw", idx),   o.pcw,  e.pcw);
    chk($sformatf("v%0d_regw", idx),  o.regw, e.regw);
    chk($sformatf("v%0d_memw", idx),  o.memw, e.memw);
    chk($sformatf("v%0d_ill", idx),   o.ill,  e.ill);
    chk($sformatf("v%0d_flags", idx), {12'b0, o.flags}, {12'b0, e.flags});
    chk($sformatf("v%0d_alu", idx),   {13'b0, o.alu},   {13'b0, e.alu});
    chk($sformatf("v%0d_sel", idx),   {10'b0, o.sel},   {10'b0, e.sel});
  endtask

  initial begin
    //            cond  op     funct      rd    aflg  st  sn len irw    pcw    regw   memw   ill    flags alu   sel
    vecs[0]  = '{4'hE, 2'b00, 6'b101000, 4'd5, 4'hF, 99, 0, 4, 16'h1, 16'h1, 16'h8, 16'h0, 16'h0, 4'h0, 3'd0, 6'h00}; // ADD imm
    vecs[1]  = '{4'hE, 2'b00, 6'b000101, 4'd3, 4'h4, 99, 0, 4, 16'h1, 16'h1, 16'h8, 16'h0, 16'h0, 4'h4, 3'd1, 6'h00}; // SUBS
    vecs[2]  = '{4'h0, 2'b00, 6'b101000, 4'd2, 4'h0, 99, 0, 4, 16'h1, 16'h1, 16'h8, 16'h0, 16'h0, 4'h4, 3'd0, 6'h00}; // ADDEQ pass
    vecs[3]  = '{4'h1, 2'b00, 6'b101001, 4'd2, 4'hB, 99, 0, 4, 16'h1, 16'h1, 16'h0, 16'h0, 16'h0, 4'h4, 3'd0, 6'h00}; // ADDSNE fail
    vecs[4]  = '{4'hE, 2'b01, 6'b011001, 4'd7, 4'h0,  3, 3, 8, 16'h1, 16'h1, 16'h80,16'h0, 16'h0, 4'h4, 3'd0, 6'h01}; // LDR, 3 stalls
    vecs[5]  = '{4'hE, 2'b00, 6'b000001, 4'd8, 4'hB, 99, 0, 4, 16'h1, 16'h1, 16'h8, 16'h0, 16'h0, 4'h8, 3'd2, 6'h00}; // ANDS keeps C,V
    vecs[6]  = '{4'h0, 2'b01, 6'b011000, 4'd4, 4'h0,  3, 1, 5, 16'h1, 16'h1, 16'h0, 16'h0, 16'h0, 4'h8, 3'd0, 6'h20}; // STREQ fail
    vecs[7]  = '{4'hE, 2'b01, 6'b011000, 4'd4, 4'h0, 99, 0, 4, 16'h1, 16'h1, 16'h0, 16'h8, 16'h0, 4'h8, 3'd0, 6'h20}; // STR
    vecs[8]  = '{4'hE, 2'b10, 6'b000000, 4'd0, 4'h0, 99, 0, 3, 16'h1, 16'h5, 16'h0, 16'h0, 16'h0, 4'h8, 3'd0, 6'h06}; // B
    vecs[9]  = '{4'h0, 2'b10, 6'b000000, 4'd0, 4'h0, 99, 0, 3, 16'h1, 16'h1, 16'h0, 16'h0, 16'h0, 4'h8, 3'd0, 6'h06}; // BEQ fail
    vecs[10] = '{4'hE, 2'b00, 6'b101000, 4'd15,4'h0, 99, 0, 4, 16'h1, 16'h9, 16'h0, 16'h0, 16'h0, 4'h8, 3'd0, 6'h00}; // ADD pc
    vecs[11] = '{4'hE, 2'b11, 6'b000000, 4'd0, 4'h0, 99, 0, 2, 16'h1, 16'h1, 16'h0, 16'h0, 16'h2, 4'h8, 3'd0, 6'h1A}; // OP=11
    vecs[12] = '{4'hE, 2'b00, 6'b000010, 4'd1, 4'h0, 99, 0, 2, 16'h1, 16'h1, 16'h0, 16'h0, 16'h2, 4'h8, 3'd0, 6'h1A}; // EOR, 2-bit ALU
    vecs[13] = '{4'hE, 2'b00, 6'b111010, 4'd1, 4'h0, 99, 0, 2, 16'h1, 16'h1, 16'h0, 16'h0, 16'h2, 4'h8, 3'd0, 6'h1A}; // MOV, 2-bit ALU
    vecs[14] = '{4'hE, 2'b00, 6'b010101, 4'd0, 4'h6, 99, 0, 4, 16'h1, 16'h1, 16'h0, 16'h0, 16'h0, 4'h6, 3'd1, 6'h00}; // CMP
    vecs[15] = '{4'h9, 2'b00, 6'b111000, 4'd1, 4'h0,  0, 1, 5, 16'h2, 16'h2, 16'h10,16'h0, 16'h0, 4'h6, 3'd3, 6'h00}; // ORRLS, fetch stall
    vecs[16] = '{4'hF, 2'b00, 6'b101000, 4'd1, 4'h0, 99, 0, 4, 16'h1, 16'h1, 16'h0, 16'h0, 16'h0, 4'h6, 3'd0, 6'h00}; // cond 1111
    vecs[17] = '{4'hE, 2'b01, 6'b011001, 4'd15,4'h0, 99, 0, 5, 16'h1, 16'h11,16'h0, 16'h0, 16'h0, 4'h6, 3'd0, 6'h01}; // LDR pc

    reset = 1'b1; MemReady = 1'b1; Cond = 4'hE; OP = 2'b00; Funct = '0; RD = '0; ALUFlags = '0;
    reset3 = 1'b1; MemReady3 = 1'b1; Cond3 = 4'hE; OP3 = 2'b00; Funct3 = 6'b000010; RD3 = 4'd6; ALUFlags3 = '0;

    // Reset state: no write enables even with MemReady high
    @(negedge clk);
    chk("rst_we", {12'b0, PCWrite, IRWrite, RegWrite, MemWrite}, 16'h0);
    chk("rst_flags", {12'b0, Flags}, 16'h0);
    chk("rst_illegal", {15'b0, Illegal}, 16'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Reset during MEMWRITE: write enable drops with no clock edge, FSM restarts in FETCH
    Cond = 4'hE; OP = 2'b01; Funct = 6'b011000; RD = 4'd4; MemReady = 1'b1;
    @(negedge clk);
    chk("final_fetch", {15'b0, IRWrite}, 16'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    MemReady = 1'b0;
    @(negedge clk);
    chk("memwr_held", {15'b0, MemWrite}, 16'h1);
    chk("str_srcs", {12'b0, RegSrc, ImmSrc}, 16'h9);
    #1 reset = 1'b1;
    #1;
    chk("rst_memw_drop", {12'b0, PCWrite, IRWrite, RegWrite, MemWrite}, 16'h0);
    chk("rst_flags_clr", {12'b0, Flags}, 16'h0);
    MemReady = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst_to_fetch", {15'b0, IRWrite}, 16'h1);

    // 3-bit ALU build: EOR is legal and shows ALUControl=4
    @(posedge clk); #1;
    reset3 = 1'b0;
    @(negedge clk);
    chk("w3_fetch", {15'b0, IRWrite3}, 16'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w3_no_illegal", {15'b0, Illegal3}, 16'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w3_eor_alu", {13'b0, ALUControl3}, 16'h4);
    chk("w3_execr_srcb", {14'b0, ALUSrcB3}, 16'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w3_wb_regw", {15'b0, RegWrite3}, 16'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
